// File: rtl/sw_pkg.sv
// Shared register map and sizing helpers for the APB switch debouncer.
package sw_pkg;

    localparam int ADDR_W = 4;
    localparam int MAX_SW = 16;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_EDGE   = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_RAW    = 2'd3
    } reg_sel_e;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_RAW    = 4'hC;

    function automatic int cnt_width(input int db_cycles);
        return (db_cycles <= 2) ? 1 : $clog2(db_cycles);
    endfunction

    // Every word slot in the 4-bit window is populated today; kept as a
    // single decode point so a sparser map only touches this function.
    function automatic logic reg_mapped(input logic [ADDR_W-1:0] addr);
        case (reg_sel_e'(addr[3:2]))
            REG_DATA, REG_EDGE, REG_IRQ_EN, REG_RAW: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sync,
    output logic stable,
    output logic toggle
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;

    // Flip happens on the cycle that would otherwise count past the limit.
    assign toggle = (sync != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= sw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (toggle) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_sw_debounce.sv
// APB slave exposing debounced switch state, sticky change flags and a level IRQ.
module apb_sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = 4,
    parameter int DATA_W    = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [N_SW-1:0]   SW,
    output logic              IRQ
);

    logic [N_SW-1:0] sync, stable, toggle;
    logic [N_SW-1:0] edge_q, irq_en_q, edge_clr;
    logic            access, wr;
    reg_sel_e        sel;
    logic            unused;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_bit (
            .clk   (PCLK),
            .rst   (PRESET),
            .sw    (SW[i]),
            .sync  (sync[i]),
            .stable(stable[i]),
            .toggle(toggle[i])
        );
    end

    assign sel     = reg_sel_e'(PADDR[3:2]);
    assign access  = PSEL && PENABLE;
    assign PSLVERR = access && !reg_mapped(PADDR);
    assign wr      = access && PWRITE && !PSLVERR;
    assign PREADY  = 1'b1;
    assign unused  = ^{PWDATA, PADDR[1:0]};

    assign edge_clr = (wr && sel == REG_EDGE) ? PWDATA[N_SW-1:0] : '0;

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (sel)
                REG_DATA:   PRDATA = DATA_W'(stable);
                REG_EDGE:   PRDATA = DATA_W'(edge_q);
                REG_IRQ_EN: PRDATA = DATA_W'(irq_en_q);
                REG_RAW:    PRDATA = DATA_W'(sync);
                default:    PRDATA = '0;
            endcase
        end
    end

    // A toggle landing in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            edge_q   <= '0;
            irq_en_q <= '0;
            IRQ      <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | toggle;
            if (wr && sel == REG_IRQ_EN)
                irq_en_q <= PWDATA[N_SW-1:0];
            IRQ <= |(edge_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_apb_sw_debounce.sv
// Directed bench for apb_sw_debounce (N_SW=4, DB_CYCLES=4, DATA_W=16).
module tb_apb_sw_debounce;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, IRQ;
    logic [3:0]  SW;

    int checks = 0;
    int errors = 0;

    apb_sw_debounce #(.N_SW(4), .DB_CYCLES(4), .DATA_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .SW(SW), .IRQ(IRQ)
    );

    always #10 PCLK = ~PCLK;

    // Zero-clock read: access phase held for 1ns inside the low clock phase.
    task automatic apb_read(input logic [3:0] a, output logic [15:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1;
        d = PRDATA; err = PSLVERR;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Called just after a negedge; commits on the second following posedge.
    task automatic apb_write(input logic [3:0] a, input logic [15:0] d,
                             output logic err, output logic [15:0] rd);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        err = PSLVERR; rd = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        e;
        PRESET = 1'b1; SW = 4'h0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        checks++;
        if (PRDATA !== 16'h0 || PREADY !== 1'b1 || IRQ !== 1'b0) begin
            errors++; $display("FAIL reset_idle: prdata=%h pready=%b irq=%b, want 0000/1/0", PRDATA, PREADY, IRQ);
        end
        for (int i = 0; i < 4; i++) begin
            apb_read(4'(i * 4), d, e);
            checks++;
            if (d !== 16'h0 || e !== 1'b0) begin
                errors++; $display("FAIL reset_reg%0d: got %h err=%b, want 0000 err=0", i, d, e);
            end
        end
    endtask

    task automatic test_debounce_timing();
        logic [15:0] d;
        logic        e;
        @(negedge PCLK);
        SW = 4'h1;
        @(negedge PCLK);
        apb_read(4'hC, d, e);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL raw_1cyc: got %h want 0000", d); end
        @(negedge PCLK);
        apb_read(4'hC, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL raw_2cyc: got %h want 0001", d); end
        repeat (3) @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL data_5cyc: got %h want 0000", d); end
        @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL data_6cyc: got %h want 0001", d); end
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL edge_rise: got %h want 0001", d); end
        repeat (2) @(negedge PCLK);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", IRQ); end
    endtask

    task automatic test_glitch();
        logic [15:0] d;
        logic        e;
        SW = 4'h3;
        repeat (3) @(negedge PCLK);
        SW = 4'h1;
        repeat (10) @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL glitch3_data: got %h want 0001", d); end
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL glitch3_edge: got %h want 0001", d); end
        SW = 4'h3;
        repeat (4) @(negedge PCLK);
        SW = 4'h1;
        repeat (2) @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h3) begin errors++; $display("FAIL pulse4_rise: got %h want 0003", d); end
        repeat (4) @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL pulse4_fall: got %h want 0001", d); end
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h3) begin errors++; $display("FAIL pulse4_edge: got %h want 0003", d); end
    endtask

    task automatic test_irq();
        logic [15:0] d, rd;
        logic        e;
        apb_write(4'h4, 16'h0002, e, rd);
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL w1c_bit1: got %h want 0001", d); end
        apb_write(4'h8, 16'hFFFF, e, rd);
        checks++;
        if (e !== 1'b0 || rd !== 16'h0) begin
            errors++; $display("FAIL write_phase: pslverr=%b prdata=%h, want 0/0000", e, rd);
        end
        apb_read(4'h8, d, e);
        checks++;
        if (d !== 16'h000F) begin errors++; $display("FAIL irq_en_mask: got %h want 000F", d); end
        apb_write(4'h8, 16'h0003, e, rd);
        apb_read(4'h8, d, e);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL irq_en_rw: got %h want 0003", d); end
        @(negedge PCLK);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", IRQ); end
        apb_write(4'h4, 16'h0001, e, rd);
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h0 || IRQ !== 1'b1) begin
            errors++; $display("FAIL w1c_bit0: edge=%h irq=%b, want 0000/1", d, IRQ);
        end
        @(negedge PCLK);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", IRQ); end
        apb_write(4'h0, 16'hFFFF, e, rd);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h1 || e !== 1'b0) begin
            errors++; $display("FAIL data_ro: got %h err=%b, want 0001 err=0", d, e);
        end
    endtask

    task automatic test_w1c_collision();
        logic [15:0] d, rd;
        logic        e;
        SW = 4'h5;
        repeat (4) @(negedge PCLK);
        apb_write(4'h4, 16'h0004, e, rd);
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h4) begin errors++; $display("FAIL set_beats_clr: got %h want 0004", d); end
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h5) begin errors++; $display("FAIL collision_data: got %h want 0005", d); end
        apb_write(4'h4, 16'h0004, e, rd);
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL w1c_bit2: got %h want 0000", d); end
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] d;
        logic        e;
        SW = 4'hD;
        repeat (4) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", d); end
        apb_read(4'h8, d, e);
        checks++;
        if (d !== 16'h0 || IRQ !== 1'b0) begin
            errors++; $display("FAIL rst_irq_en: got %h irq=%b, want 0000/0", d, IRQ);
        end
        repeat (5) @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL rst_data_5cyc: got %h want 0000", d); end
        @(negedge PCLK);
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 16'hD) begin errors++; $display("FAIL rst_data_6cyc: got %h want 000D", d); end
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 16'hD) begin errors++; $display("FAIL rst_edge: got %h want 000D", d); end
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 4'h0; PWDATA = 16'h0; SW = 4'h0;
        test_reset();
        test_debounce_timing();
        test_glitch();
        test_irq();
        test_w1c_collision();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
